branch_target_predictor: RTL and testbench

BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

---
 rtl/branch_target_predictor_pkg.sv | 27 ++
 rtl/branch_target_predictor_sat_ctr2.sv | 36 +++
 rtl/branch_target_predictor.sv | 166 ++++++++++++++++
 tb/tb_branch_target_predictor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: 2-bit counter encoding,
// clear-sweep FSM states and the per-entry state record.
package branch_target_predictor_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'd0;
    localparam ctr2_t CTR_WNT = 2'd1;
    localparam ctr2_t CTR_WT  = 2'd2;
    localparam ctr2_t CTR_ST  = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Reset-cleared part of an entry; tag and target live in unreset arrays.
    typedef struct packed {
        logic  valid;
        ctr2_t ctr;
    } btb_meta_t;

    function automatic ctr2_t alloc_ctr(input logic is_jump);
        return is_jump ? CTR_ST : CTR_WT;
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_ctr2.sv
// Next-state of a 2-bit saturating direction counter; jumps pin it to strongly taken.
module sat_ctr2
    import branch_target_predictor_pkg::*;
(
    input  ctr2_t ctr_i,
    input  logic  taken_i,
    input  logic  jump_i,
    output ctr2_t ctr_next_c
);

    ctr2_t inc_c;
    ctr2_t dec_c;

    always_comb begin
        inc_c = CTR_ST;
        dec_c = CTR_WT;
        case (ctr_i)
            CTR_SNT: begin inc_c = CTR_WNT; dec_c = CTR_SNT; end
            CTR_WNT: begin inc_c = CTR_WT;  dec_c = CTR_SNT; end
            CTR_WT:  begin inc_c = CTR_ST;  dec_c = CTR_WNT; end
            default: begin inc_c = CTR_ST;  dec_c = CTR_WT;  end
        endcase
    end

    always_comb begin
        ctr_next_c = ctr_i;
        if (jump_i) begin
            ctr_next_c = CTR_ST;
        end else if (taken_i) begin
            ctr_next_c = inc_c;
        end else begin
            ctr_next_c = dec_c;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, zero-latency
// lookup, ID-stage update, a one-entry-per-cycle clear sweep and perf counters.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_if,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispred,
    input  logic            clear_req,
    output logic            busy,
    output logic [31:0]     cnt_update,
    output logic [31:0]     cnt_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;
    localparam int unsigned CNT_W = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    btb_meta_t             meta_q   [ENTRIES];
    btb_meta_t             meta_d   [ENTRIES];
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [XLEN-1:0]       target_q [ENTRIES];

    clr_state_e            state_q, state_d;
    logic [IDX_W-1:0]      sweep_idx_q, sweep_idx_d;
    logic [CNT_W-1:0]      cnt_update_q, cnt_update_d;
    logic [CNT_W-1:0]      cnt_mispred_q, cnt_mispred_d;
    logic                  clr_en_c;

    // Lookup path
    logic [IDX_W-1:0]      lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;

    assign lk_idx = pc_if[IDX_W+1:2];
    assign lk_tag = pc_if[XLEN-1:IDX_W+2];
    assign lk_hit = meta_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);

    assign pred_taken  = lk_hit && meta_q[lk_idx].ctr[1] && !busy;
    assign pred_target = lk_hit ? target_q[lk_idx] : pc_if + XLEN'(4);

    // Update path
    logic [IDX_W-1:0]      upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    logic                  upd_accept;
    logic                  upd_write_meta;
    logic                  upd_write_data;
    ctr2_t                 hit_ctr;
    logic                  upd_pc_unused;

    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign upd_tag        = upd_pc[XLEN-1:IDX_W+2];
    assign upd_pc_unused  = ^upd_pc[1:0];
    assign upd_hit        = meta_q[upd_idx].valid && (tag_q[upd_idx] == upd_tag);
    assign upd_accept     = upd_valid && !busy && !clear_req;
    assign upd_write_meta = upd_accept && (upd_hit || upd_taken);
    assign upd_write_data = upd_accept && upd_taken;

    sat_ctr2 u_sat_ctr2 (
        .ctr_i      (meta_q[upd_idx].ctr),
        .taken_i    (upd_taken),
        .jump_i     (upd_is_jump),
        .ctr_next_c (hit_ctr)
    );

    // Clear FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear FSM: next state; a new request always restarts the sweep
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_req) state_d = ST_CLEAR;
            ST_CLEAR: if (!clear_req && (sweep_idx_q == LAST_IDX)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        busy     = 1'b0;
        clr_en_c = 1'b0;
        if (state_q == ST_CLEAR) begin
            busy     = 1'b1;
            clr_en_c = 1'b1;
        end
    end

    // Sweep index, entry state and counters next-state
    always_comb begin
        sweep_idx_d   = sweep_idx_q;
        cnt_update_d  = cnt_update_q;
        cnt_mispred_d = cnt_mispred_q;
        meta_d        = meta_q;

        if (clear_req) begin
            sweep_idx_d = '0;
        end else if (clr_en_c) begin
            sweep_idx_d = sweep_idx_q + IDX_W'(1);
        end

        if (clr_en_c) begin
            meta_d[sweep_idx_q].valid = 1'b0;
        end else if (upd_write_meta) begin
            if (upd_hit) begin
                meta_d[upd_idx] = '{valid: 1'b1, ctr: hit_ctr};
            end else begin
                meta_d[upd_idx] = '{valid: 1'b1, ctr: alloc_ctr(upd_is_jump)};
            end
        end

        if (upd_accept) begin
            cnt_update_d = cnt_update_q + CNT_W'(1);
            if (upd_mispred) begin
                cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_idx_q   <= '0;
            cnt_update_q  <= '0;
            cnt_mispred_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                meta_q[i] <= '{valid: 1'b0, ctr: CTR_SNT};
            end
        end else begin
            sweep_idx_q   <= sweep_idx_d;
            cnt_update_q  <= cnt_update_d;
            cnt_mispred_q <= cnt_mispred_d;
            meta_q        <= meta_d;
        end
    end

    // Tag and target carry no reset; valid gates every use of them
    always_ff @(posedge clk) begin
        if (upd_write_data) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    assign cnt_update  = cnt_update_q;
    assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed-vector bench for branch_target_predictor: stimulus queues expected
// lookup/status values, a negedge monitor pops and compares them.
module tb_branch_target_predictor;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_if;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_mispred;
    logic            clear_req;
    logic            busy;
    logic [31:0]     cnt_update;
    logic [31:0]     cnt_mispred;

    branch_target_predictor #(.ENTRIES(64), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_if       (pc_if),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_is_jump (upd_is_jump),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_mispred (upd_mispred),
        .clear_req   (clear_req),
        .busy        (busy),
        .cnt_update  (cnt_update),
        .cnt_mispred (cnt_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        taken;
        logic [31:0] tgt;
        logic        busy;
        logic [31:0] cu;
        logic [31:0] cm;
    } exp_t;

    exp_t        exp_q[$];
    int          total  = 0;
    int          bad    = 0;
    int          vec_id = 0;
    logic [31:0] m_cu   = 32'd0;
    logic [31:0] m_cm   = 32'd0;

    task automatic check(input int id, input string what,
                         input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL vec%0d %s: got 0x%0h want 0x%0h", id, what, act, req);
        end
    endtask

    // Monitor: outputs are stable by the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.id, "pred_taken",  32'(pred_taken), 32'(e.taken));
            check(e.id, "pred_target", pred_target,     e.tgt);
            check(e.id, "busy",        32'(busy),       32'(e.busy));
            check(e.id, "cnt_update",  cnt_update,      e.cu);
            check(e.id, "cnt_mispred", cnt_mispred,     e.cm);
        end
    end

    task automatic cyc(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic j, input logic t, input logic [31:0] tgt,
                       input logic mis, input logic clr,
                       input logic e_taken, input logic [31:0] e_tgt, input logic e_busy);
        pc_if       = pc;
        upd_valid   = uv;
        upd_pc      = upc;
        upd_is_jump = j;
        upd_taken   = t;
        upd_target  = tgt;
        upd_mispred = mis;
        clear_req   = clr;
        exp_q.push_back('{vec_id, e_taken, e_tgt, e_busy, m_cu, m_cm});
        vec_id++;
        @(posedge clk);
        #1;
        if (uv && !e_busy && !clr) begin
            m_cu = m_cu + 32'd1;
            if (mis) m_cm = m_cm + 32'd1;
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic e_taken,
                        input logic [31:0] e_tgt, input logic e_busy);
        cyc(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, e_taken, e_tgt, e_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; pc_if = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0; clear_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state, then allocate and train 0x100 (index 0)
        look(32'h100, 1'b0, 32'h104, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 1, 32'h040, 1, 0, 1'b0, 32'h104, 1'b0);
        look(32'h100, 1'b1, 32'h040, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 1'b1, 32'h040, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0, 1'b0, 32'h040, 1'b0);
        look(32'h100, 1'b0, 32'h040, 1'b0);

        // Not-taken miss is counted but allocates nothing
        cyc(32'h180, 1, 32'h180, 0, 0, 32'h0, 0, 0, 1'b0, 32'h184, 1'b0);
        look(32'h180, 1'b0, 32'h184, 1'b0);

        // Counter climbs 0->1->2->3, saturates at 3, target replaced on taken
        cyc(32'h100, 1, 32'h100, 0, 1, 32'h044, 0, 0, 1'b0, 32'h040, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 1, 32'h044, 0, 0, 1'b0, 32'h044, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 1, 32'h044, 0, 0, 1'b1, 32'h044, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 1, 32'h044, 0, 0, 1'b1, 32'h044, 1'b0);
        cyc(32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 0, 1'b1, 32'h044, 1'b0);
        look(32'h100, 1'b1, 32'h044, 1'b0);

        // Jump at 0x200 evicts 0x100 from index 0; untaken jump keeps ctr=3 and target
        cyc(32'h200, 1, 32'h200, 1, 1, 32'h080, 1, 0, 1'b0, 32'h204, 1'b0);
        look(32'h200, 1'b1, 32'h080, 1'b0);
        look(32'h100, 1'b0, 32'h104, 1'b0);
        cyc(32'h200, 1, 32'h200, 1, 0, 32'h999, 0, 0, 1'b1, 32'h080, 1'b0);
        look(32'h200, 1'b1, 32'h080, 1'b0);

        // Clear with a concurrent update; updates during the sweep are dropped
        cyc(32'h200, 1, 32'h300, 0, 1, 32'h700, 1, 1, 1'b1, 32'h080, 1'b0);
        for (int i = 0; i < 64; i++)
            cyc(32'h204, 1, 32'h300, 0, 1, 32'h700, 1, 0, 1'b0, 32'h208, 1'b1);
        look(32'h200, 1'b0, 32'h204, 1'b0);
        look(32'h300, 1'b0, 32'h304, 1'b0);
        look(32'h100, 1'b0, 32'h104, 1'b0);

        // Second clear_req mid-sweep restarts it for a full 64 cycles
        cyc(32'h204, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1'b0, 32'h208, 1'b0);
        for (int i = 0; i < 10; i++) look(32'h204, 1'b0, 32'h208, 1'b1);
        cyc(32'h204, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1'b0, 32'h208, 1'b1);
        for (int i = 0; i < 64; i++) look(32'h204, 1'b0, 32'h208, 1'b1);
        look(32'h204, 1'b0, 32'h208, 1'b0);

        // Reset at sweep index 20 aborts the clear and invalidates the table
        cyc(32'h180, 1, 32'h180, 0, 1, 32'h600, 0, 0, 1'b0, 32'h184, 1'b0);
        look(32'h180, 1'b1, 32'h600, 1'b0);
        cyc(32'h180, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1'b1, 32'h600, 1'b0);
        for (int i = 0; i < 20; i++) look(32'h180, 1'b0, 32'h600, 1'b1);
        rst = 1'b0;
        #1;
        m_cu = 32'd0;
        m_cm = 32'd0;
        exp_q.push_back('{vec_id, 1'b0, 32'h184, 1'b0, 32'd0, 32'd0});
        vec_id++;
        @(posedge clk);
        #1;
        rst = 1'b1;

        look(32'h180, 1'b0, 32'h184, 1'b0);
        cyc(32'h300, 1, 32'h300, 0, 1, 32'h500, 0, 0, 1'b0, 32'h304, 1'b0);
        look(32'h300, 1'b1, 32'h500, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
